// File: rtl/sequenciador_multiciclo.sv
// Multicycle control sequencer for the single-issue RISC-V datapath.
// Moore strobes, class-based stage skipping and a guarded MEM handshake.
module sequenciador_multiciclo #(
   parameter int unsigned PC_LIMIT    = 11,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      pc,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   input  logic             mem_ready,
   output logic [2:0]       estado,
   output logic             ir_en,
   output logic             reg_write_en,
   output logic             mem_req,
   output logic             mem_we,
   output logic             pc_en,
   output logic             pc_sel_branch,
   output logic             done,
   output logic             error,
   output logic [CNT_W-1:0] cycle_count,
   output logic [CNT_W-1:0] instr_count
);

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam int unsigned WW = $clog2(MEM_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IF    = 3'b000,
      S_ID    = 3'b001,
      S_EX    = 3'b010,
      S_MEM   = 3'b011,
      S_WB    = 3'b100,
      S_AUX   = 3'b101,
      S_SUMPC = 3'b110,
      S_FIM   = 3'b111
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [6:0]      opcode_q;
   logic            taken_q;
   logic [WW-1:0]   wait_cnt;
   logic            error_q;
   logic [CNT_W-1:0] cyc_q;
   logic [CNT_W-1:0] ins_q;

   logic            fetch_ok;
   logic            known_op;
   logic            mem_last;
   logic            mem_abort;

   assign fetch_ok = (pc < PC_LIMIT);

   assign known_op = (opcode == OP_LW)  ||
                     (opcode == OP_SW)  ||
                     (opcode == OP_R)   ||
                     (opcode == OP_I)   ||
                     (opcode == OP_BEQ);

   // Last permitted MEM cycle: a miss here aborts, a hit still completes.
   assign mem_last  = (wait_cnt == WW'(MEM_TIMEOUT - 1));
   assign mem_abort = (state == S_MEM) && !mem_ready && mem_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IF;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IF: begin
            state_nx = fetch_ok ? S_ID : S_FIM;
         end
         S_ID: begin
            state_nx = known_op ? S_EX : S_AUX;
         end
         S_EX: begin
            unique case (opcode_q)
               OP_LW, OP_SW: state_nx = S_MEM;
               OP_R, OP_I:   state_nx = S_WB;
               default:      state_nx = S_AUX;
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               state_nx = (opcode_q == OP_LW) ? S_WB : S_AUX;
            end else if (mem_last) begin
               state_nx = S_FIM;
            end else begin
               state_nx = S_MEM;
            end
         end
         S_WB:    state_nx = S_AUX;
         S_AUX:   state_nx = S_SUMPC;
         S_SUMPC: state_nx = S_IF;
         S_FIM:   state_nx = S_FIM;
         default: state_nx = S_IF;
      endcase
   end

   always_comb begin
      ir_en         = 1'b0;
      reg_write_en  = 1'b0;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      pc_en         = 1'b0;
      pc_sel_branch = 1'b0;
      done          = 1'b0;
      unique case (1'b1)
         (state == S_IF): begin
            ir_en = 1'b1;
         end
         (state == S_MEM): begin
            mem_req = 1'b1;
            mem_we  = (opcode_q == OP_SW);
         end
         (state == S_WB): begin
            reg_write_en = 1'b1;
         end
         (state == S_SUMPC): begin
            pc_en         = 1'b1;
            pc_sel_branch = taken_q;
         end
         (state == S_FIM): begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign estado      = state;
   assign error       = error_q;
   assign cycle_count = cyc_q;
   assign instr_count = ins_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         opcode_q <= '0;
      end else if (state == S_ID) begin
         opcode_q <= opcode;
      end
   end

   // Only a beq may steer the PC; other classes drop the ALU flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         taken_q <= 1'b0;
      end else if (state == S_EX) begin
         taken_q <= branch_taken && (opcode_q == OP_BEQ);
      end else if (state == S_SUMPC) begin
         taken_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt <= '0;
      end else if ((state == S_MEM) && !mem_ready && !mem_last) begin
         wait_cnt <= wait_cnt + WW'(1);
      end else begin
         wait_cnt <= '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         error_q <= 1'b0;
      end else if (mem_abort) begin
         error_q <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cyc_q <= '0;
      end else if ((state != S_FIM) && (cyc_q != '1)) begin
         cyc_q <= cyc_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ins_q <= '0;
      end else if ((state == S_SUMPC) && (ins_q != '1)) begin
         ins_q <= ins_q + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_sequenciador_multiciclo.sv
// Randomized bench for sequenciador_multiciclo against an
// instruction-level model of expected stage walks and counters.
module tb_sequenciador_multiciclo;

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EX  = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;
   localparam logic [2:0] S_AUX = 3'd5;
   localparam logic [2:0] S_SUM = 3'd6;
   localparam logic [2:0] S_FIM = 3'd7;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc = '0;
   logic [6:0]  opcode = '0;
   logic        branch_taken = 1'b0;
   logic        mem_ready = 1'b0;
   logic [2:0]  estado;
   logic        ir_en, reg_write_en, mem_req, mem_we;
   logic        pc_en, pc_sel_branch, done, error;
   logic [15:0] cycle_count, instr_count;

   int n_cmp = 0;
   int n_bad = 0;

   int         m_cyc = 0;
   int         m_ins = 0;
   bit         m_err = 1'b0;
   bit         m_tk  = 1'b0;
   logic [6:0] m_op  = '0;

   sequenciador_multiciclo #(
      .PC_LIMIT(11),
      .MEM_TIMEOUT(15),
      .CNT_W(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pc(pc),
      .opcode(opcode),
      .branch_taken(branch_taken),
      .mem_ready(mem_ready),
      .estado(estado),
      .ir_en(ir_en),
      .reg_write_en(reg_write_en),
      .mem_req(mem_req),
      .mem_we(mem_we),
      .pc_en(pc_en),
      .pc_sel_branch(pc_sel_branch),
      .done(done),
      .error(error),
      .cycle_count(cycle_count),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                  tag, got, exp, $time);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit is_known(input logic [6:0] o);
      return (o == OP_LW) || (o == OP_SW) || (o == OP_R) ||
             (o == OP_I) || (o == OP_BEQ);
   endfunction

   function automatic logic [6:0] rand_bad();
      logic [6:0] o;
      do o = 7'($urandom); while (is_known(o));
      return o;
   endfunction

   // One cycle expected in state es; called just after a rising edge.
   task automatic one(input logic [2:0] es, input logic mr,
                      input logic bt);
      logic [7:0] exp_s;
      mem_ready    = mr;
      branch_taken = bt;
      @(negedge clk);
      exp_s = {es == S_IF, es == S_WB, es == S_MEM,
               (es == S_MEM) && (m_op == OP_SW), es == S_SUM,
               (es == S_SUM) && m_tk, es == S_FIM, m_err};
      chk("estado", 32'(estado), 32'(es));
      chk("strobes", 32'({ir_en, reg_write_en, mem_req, mem_we, pc_en,
                          pc_sel_branch, done, error}), 32'(exp_s));
      chk("cycle_count", 32'(cycle_count), 32'(m_cyc));
      chk("instr_count", 32'(instr_count), 32'(m_ins));
      @(posedge clk);
      if (es != S_FIM && m_cyc < 65535) m_cyc++;
      if (es == S_SUM && m_ins < 65535) m_ins++;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      #2;
      chk("rst_estado", 32'(estado), 32'(S_IF));
      chk("rst_strobes", 32'({reg_write_en, mem_req, mem_we, pc_en,
                              pc_sel_branch, done, error}), 32'(0));
      chk("rst_counts", {cycle_count, instr_count}, 32'(0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_cyc = 0;
      m_ins = 0;
      m_err = 1'b0;
      m_tk  = 1'b0;
   endtask

   // Walks one instruction through the stages its class requires.
   task automatic run_instr(input logic [6:0] op, input bit tk,
                            input int wt, input logic [31:0] pcv);
      m_op   = op;
      m_tk   = (op == OP_BEQ) && tk;
      pc     = pcv;
      opcode = 7'($urandom);
      one(S_IF, rb(), rb());
      opcode = op;
      one(S_ID, rb(), rb());
      opcode = 7'($urandom);
      if (op == OP_LW || op == OP_SW) begin
         one(S_EX, rb(), rb());
         for (int k = 0; k < 15; k++) begin
            one(S_MEM, 1'(k == wt), rb());
            if (k == wt) break;
         end
         if (wt >= 15) begin
            m_err = 1'b1;
            return;
         end
         if (op == OP_LW) one(S_WB, rb(), rb());
      end else if (op == OP_R || op == OP_I) begin
         one(S_EX, rb(), rb());
         one(S_WB, rb(), rb());
      end else if (op == OP_BEQ) begin
         one(S_EX, rb(), 1'(tk));
      end
      one(S_AUX, rb(), rb());
      one(S_SUM, rb(), rb());
   endtask

   initial begin
      logic [6:0] op;
      do_reset();

      run_instr(OP_LW, 1'b0, 0, 32'd0);
      chk("lw_cycles", 32'(cycle_count), 32'd7);
      chk("lw_instrs", 32'(instr_count), 32'd1);
      run_instr(OP_SW, 1'b0, 3, 32'd1);
      run_instr(OP_BEQ, 1'b1, 0, 32'd2);
      run_instr(OP_BEQ, 1'b0, 0, 32'd3);
      run_instr(OP_I, 1'b0, 0, 32'd4);
      run_instr(OP_BAD, 1'b0, 0, 32'd5);
      run_instr(OP_R, 1'b1, 0, 32'd10);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 5))
            0: op = OP_LW;
            1: op = OP_SW;
            2: op = OP_R;
            3: op = OP_I;
            4: op = OP_BEQ;
            default: op = rand_bad();
         endcase
         run_instr(op, 1'(rb()), int'($urandom_range(0, 4)),
                   32'($urandom_range(0, 10)));
      end

      run_instr(OP_LW, 1'b0, 15, 32'd3);
      repeat (3) one(S_FIM, rb(), rb());
      do_reset();

      run_instr(OP_LW, 1'b0, 14, 32'd3);
      run_instr(OP_SW, 1'b0, 14, 32'd4);

      m_op = OP_LW;
      m_tk = 1'b0;
      pc = 32'd2;
      opcode = OP_LW;
      one(S_IF, 1'b0, 1'b0);
      one(S_ID, 1'b0, 1'b0);
      opcode = 7'($urandom);
      one(S_EX, 1'b0, 1'b0);
      one(S_MEM, 1'b0, 1'b0);
      do_reset();

      run_instr(OP_SW, 1'b0, 1, 32'd0);

      pc = 32'd11;
      one(S_IF, rb(), rb());
      repeat (20) one(S_FIM, rb(), rb());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
